// File: rtl/rmac_accumulator_if.sv
// Handshake bundle between the approximate multiplier, the
// FP32 group accumulator and the sum consumer.
interface rmac_accumulator_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [7:0]       in_exp;
    logic [22:0]      in_mantissa;
    logic             in_last;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [7:0]       out_exp;
    logic [22:0]      out_mantissa;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_sign, in_exp, in_mantissa,
        output in_last, clear, out_ready,
        input  in_ready, out_valid, out_sign, out_exp,
        input  out_mantissa, out_count
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mantissa,
        input  in_last, clear, out_ready,
        output in_ready, out_valid, out_sign, out_exp,
        output out_mantissa, out_count
    );
endinterface

// File: rtl/rmac_accumulator.sv
// Multi-cycle FP32 group accumulator: align, add, normalize,
// truncating arithmetic with exponent saturation and flush-to-zero.
module rmac_accumulator #(
    parameter int GUARD = 3,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    rmac_accumulator_if.slave bus
);
    localparam int SW  = 24 + GUARD;
    localparam int LZW = $clog2(SW + 1);

    typedef enum logic [2:0] {
        IDLE, ALIGN, ADD, NORM, DONE
    } state_t;

    state_t state, nxt;

    logic             acc_sign;
    logic [7:0]       acc_exp;
    logic [22:0]      acc_mant;
    logic [CNT_W-1:0] count;

    logic             term_sign;
    logic [7:0]       term_exp;
    logic [22:0]      term_mant;
    logic             last_q;

    logic             big_sign;
    logic [7:0]       big_exp;
    logic [SW-1:0]    big_sig;
    logic [SW-1:0]    small_sig;
    logic             sub_q;
    logic [SW:0]      sum_q;

    logic             acc_zero;
    logic             term_big;
    logic             a_sign;
    logic             a_sub;
    logic [7:0]       a_exp;
    logic [7:0]       a_shift;
    logic [SW-1:0]    a_big;
    logic [SW-1:0]    a_small;

    logic             n_sign;
    logic [7:0]       n_exp;
    logic [22:0]      n_mant;
    logic [LZW-1:0]   lz;
    logic signed [9:0] n_e;

    function automatic logic [LZW-1:0] lzc(
        input logic [SW-1:0] v
    );
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) lzc = LZW'(SW - 1 - i);
    endfunction

    assign acc_zero = (acc_exp == 8'd0);
    assign term_big = acc_zero ||
        ({term_exp, term_mant} >= {acc_exp, acc_mant});

    // Magnitude ordering decides which operand is shifted.
    always_comb begin
        a_sign  = term_sign;
        a_exp   = term_exp;
        a_big   = {1'b1, term_mant, GUARD'(0)};
        a_small = '0;
        a_shift = '0;
        a_sub   = 1'b0;
        if (term_big) begin
            a_shift = term_exp - acc_exp;
            a_small = {1'b1, acc_mant, GUARD'(0)};
            a_sub   = term_sign ^ acc_sign;
        end else begin
            a_sign  = acc_sign;
            a_exp   = acc_exp;
            a_big   = {1'b1, acc_mant, GUARD'(0)};
            a_shift = acc_exp - term_exp;
            a_small = {1'b1, term_mant, GUARD'(0)};
            a_sub   = term_sign ^ acc_sign;
        end
        if (acc_zero || a_shift >= 8'(SW))
            a_small = '0;
        else
            a_small = a_small >> a_shift;
    end

    always_comb begin
        lz     = lzc(sum_q[SW-1:0]);
        n_sign = big_sign;
        n_e    = '0;
        n_mant = '0;
        if (sum_q == '0) begin
            n_sign = 1'b0;
        end else if (sum_q[SW]) begin
            n_e    = $signed({2'b00, big_exp}) + 10'sd1;
            n_mant = 23'(sum_q >> (GUARD + 1));
        end else begin
            n_e    = $signed({2'b00, big_exp})
                   - $signed(10'(lz));
            n_mant = 23'((sum_q[SW-1:0] << lz) >> GUARD);
        end
        n_exp = n_e[7:0];
        if (n_e > 10'sd254) begin
            n_exp  = 8'd254;
            n_mant = 23'h7FFFFF;
        end else if (n_e < 10'sd1) begin
            n_sign = 1'b0;
            n_exp  = 8'd0;
            n_mant = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:
                if (!bus.clear && bus.in_valid) nxt = ALIGN;
            ALIGN: nxt = ADD;
            ADD:   nxt = NORM;
            NORM:  nxt = last_q ? DONE : IDLE;
            DONE:
                if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sign  <= 1'b0;
            acc_exp   <= '0;
            acc_mant  <= '0;
            count     <= '0;
            term_sign <= 1'b0;
            term_exp  <= '0;
            term_mant <= '0;
            last_q    <= 1'b0;
            big_sign  <= 1'b0;
            big_exp   <= '0;
            big_sig   <= '0;
            small_sig <= '0;
            sub_q     <= 1'b0;
            sum_q     <= '0;
        end else begin
            unique case (state)
                IDLE:
                    if (bus.clear) begin
                        acc_sign <= 1'b0;
                        acc_exp  <= '0;
                        acc_mant <= '0;
                        count    <= '0;
                    end else if (bus.in_valid) begin
                        term_sign <= bus.in_sign;
                        term_exp  <= bus.in_exp;
                        term_mant <= bus.in_mantissa;
                        last_q    <= bus.in_last;
                    end
                ALIGN: begin
                    big_sign  <= a_sign;
                    big_exp   <= a_exp;
                    big_sig   <= a_big;
                    small_sig <= a_small;
                    sub_q     <= a_sub;
                end
                ADD:
                    if (sub_q)
                        sum_q <= {1'b0, big_sig} - {1'b0, small_sig};
                    else
                        sum_q <= {1'b0, big_sig} + {1'b0, small_sig};
                NORM: begin
                    acc_sign <= n_sign;
                    acc_exp  <= n_exp;
                    acc_mant <= n_mant;
                    if (count != '1) count <= count + 1'b1;
                end
                DONE:
                    if (bus.out_ready) begin
                        acc_sign <= 1'b0;
                        acc_exp  <= '0;
                        acc_mant <= '0;
                        count    <= '0;
                    end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = (state == DONE);
    assign bus.out_sign     = bus.out_valid & acc_sign;
    assign bus.out_exp      = bus.out_valid ? acc_exp : '0;
    assign bus.out_mantissa = bus.out_valid ? acc_mant : '0;
    assign bus.out_count    = bus.out_valid ? count : '0;
endmodule

// File: tb/tb_rmac_accumulator.sv
// Directed and randomized checks of the group accumulator
// against an arithmetic model of truncating FP32 accumulation.
module tb_rmac_accumulator;
    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    logic [31:0] acc_m;
    logic [31:0] t;
    int   n;

    always #5 clk = ~clk;

    rmac_accumulator_if #(.CNT_W(16)) bus ();

    rmac_accumulator #(
        .GUARD(3),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h",
                    tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!bus.in_ready && k < 20) begin
            tick;
            k++;
        end
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic send(input string tag,
                        input logic [31:0] v,
                        input logic last);
        wait_ready(tag);
        bus.in_valid    = 1'b1;
        bus.in_sign     = v[31];
        bus.in_exp      = v[30:23];
        bus.in_mantissa = v[22:0];
        bus.in_last     = last;
        tick;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic recv(input string tag,
                        input logic [31:0] v,
                        input int cnt,
                        input int delay);
        int k = 0;
        while (!bus.out_valid && k < 20) begin
            tick;
            k++;
        end
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_value"},
            64'({bus.out_sign, bus.out_exp, bus.out_mantissa}),
            64'(v));
        chk({tag, "_count"}, 64'(bus.out_count), 64'(cnt));
        repeat (delay) tick;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    // Reference: value = 1.m * 2^(e-127), aligned to 3 guard bits
    // below the larger operand's LSB, then truncated to 23 bits.
    function automatic logic [31:0] fadd(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [31:0] bg, sm;
        logic [63:0] bu, su, r;
        int sh, p, e;
        logic [22:0] mt;
        if (a[30:23] == 0) begin
            bg = b; sm = '0;
        end else if (a[30:0] > b[30:0]) begin
            bg = a; sm = b;
        end else begin
            bg = b; sm = a;
        end
        bu = {40'd0, 1'b1, bg[22:0]} << 3;
        su = '0;
        if (sm[30:23] != 0) begin
            sh = int'(bg[30:23]) - int'(sm[30:23]);
            if (sh < 27)
                su = ({40'd0, 1'b1, sm[22:0]} << 3) >> sh;
        end
        r = (bg[31] == sm[31]) ? bu + su : bu - su;
        if (r == 0) return '0;
        p = 0;
        for (int i = 0; i < 40; i++)
            if (r[i]) p = i;
        e = int'(bg[30:23]) + p - 26;
        if (p >= 23) mt = 23'(r >> (p - 23));
        else         mt = 23'(r << (23 - p));
        if (e > 254) return {bg[31], 8'd254, 23'h7FFFFF};
        if (e < 1)   return '0;
        return {bg[31], 8'(e), mt};
    endfunction

    function automatic logic [31:0] rnd_term();
        logic [7:0] e;
        if ($urandom_range(0, 9) < 7)
            e = 8'($urandom_range(120, 134));
        else
            e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_exp      = '0;
        bus.in_mantissa = '0;
        bus.in_last     = 1'b0;
        bus.clear       = 1'b0;
        bus.out_ready   = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_fields",
            64'({bus.out_sign, bus.out_exp, bus.out_mantissa}),
            64'd0);
        chk("rst_out_count", 64'(bus.out_count), 64'd0);

        send("lat", {1'b0, 8'd127, 23'h400000}, 1'b1);
        tick;
        tick;
        chk("lat_early", 64'(bus.out_valid), 64'd0);
        tick;
        chk("lat_t3", 64'(bus.out_valid), 64'd1);
        recv("one", {1'b0, 8'd127, 23'h400000}, 1, 0);

        send("two", {1'b0, 8'd127, 23'h0}, 1'b0);
        send("two", {1'b0, 8'd127, 23'h0}, 1'b1);
        recv("two", {1'b0, 8'd128, 23'h0}, 2, 1);

        send("cancel", {1'b0, 8'd127, 23'h400000}, 1'b0);
        send("cancel", {1'b1, 8'd127, 23'h400000}, 1'b1);
        recv("cancel", 32'd0, 2, 0);

        send("neg", {1'b0, 8'd127, 23'h0}, 1'b0);
        send("neg", {1'b1, 8'd127, 23'h400000}, 1'b1);
        recv("neg", {1'b1, 8'd126, 23'h0}, 2, 0);

        send("tiny", {1'b0, 8'd127, 23'h0}, 1'b0);
        send("tiny", {1'b0, 8'd90, 23'h0}, 1'b1);
        recv("tiny", {1'b0, 8'd127, 23'h0}, 2, 0);

        send("sat", {1'b0, 8'd254, 23'h7FFFFF}, 1'b0);
        send("sat", {1'b0, 8'd254, 23'h7FFFFF}, 1'b1);
        recv("sat", {1'b0, 8'd254, 23'h7FFFFF}, 2, 0);
        send("fresh", {1'b0, 8'd127, 23'h0}, 1'b1);
        recv("fresh", {1'b0, 8'd127, 23'h0}, 1, 0);

        send("hold", {1'b0, 8'd127, 23'h400000}, 1'b1);
        tick;
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_sign     = 1'b0;
            bus.in_exp      = 8'd128;
            bus.in_mantissa = '0;
            bus.in_last     = 1'b1;
            tick;
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_value",
                64'({bus.out_sign, bus.out_exp,
                     bus.out_mantissa}),
                64'({1'b0, 8'd127, 23'h400000}));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        recv("hold", {1'b0, 8'd127, 23'h400000}, 1, 0);
        chk("hold_idle", 64'(bus.out_count), 64'd0);

        send("clr", {1'b0, 8'd127, 23'h0}, 1'b0);
        wait_ready("clr");
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        send("clr", {1'b0, 8'd128, 23'h0}, 1'b1);
        recv("clr", {1'b0, 8'd128, 23'h0}, 1, 0);

        send("rstadd", {1'b0, 8'd127, 23'h0}, 1'b0);
        send("rstadd", {1'b0, 8'd127, 23'h0}, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rstadd_ready", 64'(bus.in_ready), 64'd1);
        chk("rstadd_valid", 64'(bus.out_valid), 64'd0);
        send("rstadd", {1'b0, 8'd127, 23'h400000}, 1'b1);
        recv("rstadd", {1'b0, 8'd127, 23'h400000}, 1, 0);

        for (int g = 0; g < 30; g++) begin
            acc_m = '0;
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                t = rnd_term();
                acc_m = fadd(acc_m, t);
                send("rnd", t, 1'(k == n - 1));
            end
            recv("rnd", acc_m, n, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
